// File: rtl/ipu_frame_sched_if.sv
// Signal bundle between the frame scheduler (master) and camera / IPU / consumer side (slave).
// CNT_W must match the scheduler's CNT_W.
interface ipu_frame_sched_if #(
  parameter int CNT_W = 16
);
  logic             iArm;
  logic             iContinuous;
  logic             iDVAL;
  logic [10:0]      iX_Cont;
  logic [10:0]      iY_Cont;
  logic             oIPU_DVAL;
  logic             oIPU_Clr;
  logic             iIPU_DVAL;
  logic [10:0]      iIPU_Row;
  logic [10:0]      iIPU_Col;
  logic             iIPU_Present;
  logic [10:0]      oRow;
  logic [10:0]      oCol;
  logic             oPresent;
  logic             oValid;
  logic             iReady;
  logic             oBusy;
  logic             oResTmo;
  logic             oTimeout;
  logic [CNT_W-1:0] oFrameCnt;

  modport master (
    input  iArm, iContinuous, iDVAL, iX_Cont, iY_Cont,
           iIPU_DVAL, iIPU_Row, iIPU_Col, iIPU_Present, iReady,
    output oIPU_DVAL, oIPU_Clr, oRow, oCol, oPresent, oValid,
           oBusy, oResTmo, oTimeout, oFrameCnt
  );

  modport slave (
    output iArm, iContinuous, iDVAL, iX_Cont, iY_Cont,
           iIPU_DVAL, iIPU_Row, iIPU_Col, iIPU_Present, iReady,
    input  oIPU_DVAL, oIPU_Clr, oRow, oCol, oPresent, oValid,
           oBusy, oResTmo, oTimeout, oFrameCnt
  );
endinterface

// File: rtl/ipu_frame_sched.sv
// Frame-level capture sequencer: gates one camera frame into the IPU and returns its centroid.
// Optional start-of-frame watchdog enabled by defining WATCHDOG_EN.
//
// state      | meaning
// S_IDLE     | waiting for iArm
// S_CLEAR    | one-cycle IPU accumulator clear
// S_WAIT_SOF | waiting for pixel (0,0); SOF pixel is gated through
// S_CAPTURE  | every valid pixel gated to IPU until EOF pixel
// S_WAIT_RES | waiting up to RESULT_WAIT cycles for IPU result
// S_HOLD     | result presented, waiting for iReady
module ipu_frame_sched #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int RESULT_WAIT = 64,
`ifdef WATCHDOG_EN
  parameter int TIMEOUT_CYCLES = 2000000,
`endif
  parameter int CNT_W       = 16
) (
  input logic               iCLK,
  input logic               iRST,
  ipu_frame_sched_if.master bus
);
  localparam int RW_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
  localparam logic [RW_W-1:0] RW_LOAD = RW_W'(RESULT_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_SOF, S_CAPTURE, S_WAIT_RES, S_HOLD
  } state_t;

  state_t           state, state_nxt;
  logic             sof, eof, gate;
  logic             arm_go, eof_hit, res_hit, res_tmo;
  logic [RW_W-1:0]  rw_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [10:0]      row_q, col_q;
  logic             present_q, res_tmo_q;

`ifdef WATCHDOG_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wd_cnt;
  logic            wd_fire;
  logic            timeout_q;
`endif

  assign sof = bus.iDVAL && (bus.iX_Cont == 11'd0) && (bus.iY_Cont == 11'd0);
  assign eof = bus.iDVAL && (bus.iX_Cont == 11'(H_ACTIVE - 1))
                         && (bus.iY_Cont == 11'(V_ACTIVE - 1));

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gate      = 1'b0;
    arm_go    = 1'b0;
    eof_hit   = 1'b0;
    res_hit   = 1'b0;
    res_tmo   = 1'b0;
`ifdef WATCHDOG_EN
    wd_fire   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.iArm) begin
          arm_go    = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: state_nxt = S_WAIT_SOF;
      S_WAIT_SOF: begin
        gate = sof;
        if (sof) state_nxt = S_CAPTURE;
`ifdef WATCHDOG_EN
        else if (wd_cnt == '0) begin
          wd_fire   = 1'b1;
          state_nxt = S_IDLE;
        end
`endif
      end
      S_CAPTURE: begin
        gate = 1'b1;
        if (eof) begin
          eof_hit   = 1'b1;
          state_nxt = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        // a result in the final wait cycle still wins over the timeout
        if (bus.iIPU_DVAL) begin
          res_hit   = 1'b1;
          state_nxt = S_HOLD;
        end else if (rw_cnt == '0) begin
          res_tmo   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.iReady) state_nxt = bus.iContinuous ? S_CLEAR : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rw_cnt    <= '0;
      frame_cnt <= '0;
      row_q     <= '0;
      col_q     <= '0;
      present_q <= 1'b0;
      res_tmo_q <= 1'b0;
    end else begin
      if (arm_go) res_tmo_q <= 1'b0;
      if (eof_hit) begin
        frame_cnt <= frame_cnt + 1'b1;
        rw_cnt    <= RW_LOAD;
      end else if (state == S_WAIT_RES && rw_cnt != '0) begin
        rw_cnt <= rw_cnt - 1'b1;
      end
      if (res_hit) begin
        row_q     <= bus.iIPU_Row;
        col_q     <= bus.iIPU_Col;
        present_q <= bus.iIPU_Present;
      end else if (res_tmo) begin
        row_q     <= '0;
        col_q     <= '0;
        present_q <= 1'b0;
        res_tmo_q <= 1'b1;
      end
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // reload everywhere outside WAIT_SOF so each wait starts from the full limit
      if (state != S_WAIT_SOF)  wd_cnt <= TO_LOAD;
      else if (wd_cnt != '0)    wd_cnt <= wd_cnt - 1'b1;
      if (arm_go)       timeout_q <= 1'b0;
      else if (wd_fire) timeout_q <= 1'b1;
    end
  end
  assign bus.oTimeout = timeout_q;
`else
  assign bus.oTimeout = 1'b0;
`endif

  assign bus.oIPU_DVAL = bus.iDVAL && gate;
  assign bus.oIPU_Clr  = (state == S_CLEAR);
  assign bus.oBusy     = (state != S_IDLE);
  assign bus.oValid    = (state == S_HOLD);
  assign bus.oRow      = row_q;
  assign bus.oCol      = col_q;
  assign bus.oPresent  = present_q;
  assign bus.oResTmo   = res_tmo_q;
  assign bus.oFrameCnt = frame_cnt;
endmodule
